// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM state encoding,
// error codes and byte-lane positions within a big-endian word.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  // Byte-lane index in arrival order; lane 0 carries bits [31:24].
  localparam logic [1:0] LANE_MSB  = 2'd0;
  localparam logic [1:0] LANE_LAST = 2'd3;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Collects four accepted bytes (first byte most significant) and presents
// the completed 32-bit word together with a one-cycle word_valid strobe.
module boot_loader_byte_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // The fourth byte is forwarded combinationally so the word is usable on its own handshake.
  assign word_valid = byte_valid && (cnt_q == LANE_LAST);
  assign word       = {shift_q, byte_data};

  // Byte counter and shift register next-state.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr) begin
      cnt_d   = LANE_MSB;
      shift_d = 24'h00_0000;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_data};
    end else begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= LANE_MSB;
      shift_q <= 24'h00_0000;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: length header, big-endian payload words into the
// instruction memory, CPU held in reset until done. BOOT_CHECKSUM_EN adds a trailing checksum word.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 9
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_reset,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

`ifdef BOOT_CHECKSUM_EN
  localparam state_e ST_AFTER_PAYLOAD = ST_CSUM;
`else
  localparam state_e ST_AFTER_PAYLOAD = ST_DONE;
`endif

  state_e             state_q, state_d;
  logic [31:0]        len_q, len_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               in_ready_q, in_ready_d;
  logic               im_we_q, im_we_d;
  logic [31:0]        im_addr_q, im_addr_d;
  logic [31:0]        im_wdata_q, im_wdata_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]        csum_q, csum_d;
`endif

  logic               accept;
  logic               pack_clr;
  logic               word_valid;
  logic [31:0]        word;
  logic [31:0]        wcnt_ext;

  assign accept   = in_valid && in_ready_q;
  assign wcnt_ext = {{(32-CNT_W){1'b0}}, wcnt_q};

  boot_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (Reset),
    .clr        (pack_clr),
    .byte_valid (accept),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state and output decode; status outputs follow the state being entered.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    err_d      = err_q;
    pack_clr   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d  = ST_LEN;
          wcnt_d   = {CNT_W{1'b0}};
          err_d    = ERR_NONE;
          pack_clr = 1'b1;
`ifdef BOOT_CHECKSUM_EN
          csum_d   = 32'h0000_0000;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (word_valid) begin
          len_d = word;
          if (word == 32'h0000_0000) begin
            state_d = ST_AFTER_PAYLOAD;
          end else if (word > MAX_WORDS_W) begin
            state_d = ST_ERROR;
            err_d   = ERR_LEN;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          im_we_d    = 1'b1;
          im_wdata_d = word;
          im_addr_d  = BASE_ADDR + {wcnt_ext[29:0], 2'b00};
          wcnt_d     = wcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef BOOT_CHECKSUM_EN
          csum_d     = csum_q + word;
`endif
          // len_q is at least 1 here, so the subtraction cannot wrap.
          if (wcnt_ext == (len_q - 32'd1)) begin
            state_d = ST_AFTER_PAYLOAD;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM: begin
        if (word_valid) begin
          if (word == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_CSUM;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_LEN) || (state_d == ST_LOAD) || (state_d == ST_CSUM);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    cpu_reset_d = (state_d != ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      len_q       <= 32'h0000_0000;
      wcnt_q      <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      im_addr_q   <= BASE_ADDR;
      im_wdata_q  <= 32'h0000_0000;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      in_ready_q  <= in_ready_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_q       <= err_d;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running modulo-2^32 sum of payload words.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      csum_q <= 32'h0000_0000;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign in_ready   = in_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_q;
  assign word_count = wcnt_q;

endmodule
